enemy_formation_ctrl: RTL and testbench
=======================================

// Module: enemy_formation_ctrl
// PURPOSE
//  Upstream movement controller for the invader grid. Once per frame it decides how the whole
//  formation marches: horizontal direction, drop-down phases and current formation origin.
//  It drives enemy_direction_X/Y into every enemy sprite instance and raises invaded or
//  wave_clear to the game FSM. Speed rises as alive_count falls.
// PARAMETERS
//  INIT_X      10'd40   formation left edge after reset/start (px)
//  INIT_Y      10'd40   formation top edge after reset/start (px)
//  FORM_W      10'd400  formation width (px)
//  FORM_H      10'd200  formation height (px)
//  LEFT_EDGE   10'd8    leftmost allowed x (px)
//  RIGHT_EDGE  10'd632  rightmost allowed x, exclusive (px)
//  LOSE_Y      10'd420  bottom line; formation bottom >= LOSE_Y is invasion
//  STEP_X      4        px per march tick
//  DROP_FRAMES 8        frames (= px) per drop phase
//  BASE_PERIOD 30       frames per march tick at full formation
//  MIN_PERIOD  2        fastest march period (frames)
//  SPEEDUP     1        frames removed from period per killed enemy
//  MAX_ALIVE   24       enemy count of a full wave
// PORTS
//  frame_clk          in   1   frame-rate clock (vsync)
//  Reset              in   1   synchronous, active-high
//  start              in   1   begin wave (level, sampled in IDLE)
//  is_playing         in   1   0 = pause: all state/counters hold
//  alive_count        in   6   live enemies, 0..MAX_ALIVE
//  enemy_direction_X  out  1   0 = left, 1 = right
//  enemy_direction_Y  out  1   1 while dropping
//  formation_x        out  10  current left edge (px)
//  formation_y        out  10  current top edge (px)
//  move_tick          out  1   high for one frame when a horizontal step is taken
//  invaded            out  1   sticky; formation reached LOSE_Y
//  wave_clear         out  1   sticky; alive_count reached 0
// BEHAVIOUR
//  Reset values: state IDLE, formation_x=INIT_X, formation_y=INIT_Y, dir_X=1, dir_Y=0,
//   move_tick=0, invaded=0, wave_clear=0, frame_cnt=0. Reset wins over all events, any state.
//  States: IDLE, MARCH, DROP, HALT. All outputs registered; update on frame_clk edge.
//  IDLE: hold reset values; start=1 -> MARCH, frame_cnt=0.
//  period = max(MIN_PERIOD, BASE_PERIOD - (MAX_ALIVE - alive_count)*SPEEDUP), 8-bit signed-safe
//   arithmetic (no underflow; clamp at MIN_PERIOD). alive_count > MAX_ALIVE treated as MAX_ALIVE.
//  MARCH: frame_cnt++ each frame; when frame_cnt >= period-1: frame_cnt<=0 and tick:
//   - dir_X=1, formation_x+FORM_W+STEP_X > RIGHT_EDGE: no x move, move_tick=0, dir_X<=0,
//     dir_Y<=1, -> DROP.
//   - dir_X=0, formation_x < LEFT_EDGE+STEP_X: no x move, move_tick=0, dir_X<=1, dir_Y<=1, -> DROP.
//   - else formation_x +/- STEP_X, move_tick=1 for exactly that frame.
//  DROP: drop_cnt counts DROP_FRAMES frames; formation_y++ each frame, dir_Y=1 throughout.
//   After last drop frame: dir_Y<=0, frame_cnt<=0; if formation_y+FORM_H >= LOSE_Y -> HALT with
//   invaded<=1, else -> MARCH.
//  HALT: all outputs hold; dir_Y=0, move_tick=0. Leaves only via Reset.
//  alive_count==0 while in MARCH or DROP -> HALT next frame, wave_clear<=1, no further move;
//   takes priority over a same-frame edge hit or invasion (invaded stays 0).
//  is_playing=0: hold state, counters, positions; move_tick forced 0; dir_Y holds.
//  Reset mid-DROP: formation_y returns to INIT_Y, dir_Y=0 on the next frame.
// TESTING
//  1 Reset, start=1, alive=24: after 30 frames formation_x 40->44, move_tick high 1 frame only.
//  2 alive=24, run: 48 ticks to formation_x=232; 49th tick -> dir_X=0, dir_Y=1 for exactly
//    8 frames, formation_y 40->48, formation_x stays 232, then MARCH left.
//  3 alive=4 -> tick spacing 10 frames; alive=1 -> 7 frames; alive=0 -> wave_clear=1, HALT,
//    formation_x frozen.
//  4 INIT_Y=10'd216 override, drive to first drop: formation_y=224, invaded=1, state HALT.
//  5 is_playing=0 for 50 frames mid-MARCH: formation_x, frame_cnt unchanged, move_tick=0.
//  6 Reset asserted during DROP frame 4: next frame formation_x=40, formation_y=40,
//    dir_X=1, dir_Y=0, state IDLE; alive=0 and edge on same tick -> wave_clear=1, invaded=0.

Source files
------------

// File: rtl/enemy_formation_if.sv
// Bundle between the game FSM and the invader formation controller.
interface enemy_formation_if;
    logic       start;
    logic       is_playing;
    logic [5:0] alive_count;
    logic       enemy_direction_X;
    logic       enemy_direction_Y;
    logic [9:0] formation_x;
    logic [9:0] formation_y;
    logic       move_tick;
    logic       invaded;
    logic       wave_clear;

    modport master (
        output start, is_playing, alive_count,
        input  enemy_direction_X, enemy_direction_Y, formation_x, formation_y,
               move_tick, invaded, wave_clear
    );

    modport slave (
        input  start, is_playing, alive_count,
        output enemy_direction_X, enemy_direction_Y, formation_x, formation_y,
               move_tick, invaded, wave_clear
    );
endinterface

// File: rtl/enemy_formation_ctrl.sv
// Per-frame march controller for the invader grid: horizontal steps, drop phases,
// speed-up as enemies die, and sticky invaded / wave_clear flags.
module enemy_formation_ctrl #(
    parameter logic [9:0]  INIT_X      = 10'd40,
    parameter logic [9:0]  INIT_Y      = 10'd40,
    parameter logic [9:0]  FORM_W      = 10'd400,
    parameter logic [9:0]  FORM_H      = 10'd200,
    parameter logic [9:0]  LEFT_EDGE   = 10'd8,
    parameter logic [9:0]  RIGHT_EDGE  = 10'd632,
    parameter logic [9:0]  LOSE_Y      = 10'd420,
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned DROP_FRAMES = 8,
    parameter int unsigned BASE_PERIOD = 30,
    parameter int unsigned MIN_PERIOD  = 2,
    parameter int unsigned SPEEDUP     = 1,
    parameter int unsigned MAX_ALIVE   = 24
) (
    input  logic              frame_clk,
    input  logic              Reset,
    enemy_formation_if.slave  bus
);

    localparam int unsigned XW = 10;
    localparam int unsigned EW = 11;
    localparam int unsigned CW = 8;
    localparam int unsigned PW = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARCH = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic          dirx_q, dirx_d;
    logic          diry_q, diry_d;
    logic          tick_q, tick_d;
    logic          inv_q, inv_d;
    logic          clr_q, clr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic [5:0]    alive_sat;
    logic [PW-1:0] speed_dec;
    logic [CW-1:0] period;
    logic [CW-1:0] period_m1;
    logic          hit_right;
    logic          hit_left;
    logic          reach_lose;

    // March period shrinks with kills; computed wide so it can never wrap below MIN_PERIOD.
    always_comb begin
        alive_sat = (bus.alive_count > 6'(MAX_ALIVE)) ? 6'(MAX_ALIVE) : bus.alive_count;
        speed_dec = (PW'(MAX_ALIVE) - PW'(alive_sat)) * PW'(SPEEDUP);
        if (speed_dec + PW'(MIN_PERIOD) > PW'(BASE_PERIOD)) begin
            period = CW'(MIN_PERIOD);
        end else begin
            period = CW'(PW'(BASE_PERIOD) - speed_dec);
        end
        period_m1 = period - CW'(1);
    end

    assign hit_right  = (EW'(x_q) + EW'(FORM_W) + EW'(STEP_X)) > EW'(RIGHT_EDGE);
    assign hit_left   = EW'(x_q) < (EW'(LEFT_EDGE) + EW'(STEP_X));
    assign reach_lose = (EW'(y_q) + EW'(1) + EW'(FORM_H)) >= EW'(LOSE_Y);

    // Next-state and next-output logic; everything holds while paused.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        tick_d  = 1'b0;
        inv_d   = inv_q;
        clr_d   = clr_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;

        if (bus.is_playing) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = MARCH;
                        fcnt_d  = '0;
                    end
                end
                MARCH: begin
                    if (bus.alive_count == 6'd0) begin
                        state_d = HALT;
                        clr_d   = 1'b1;
                        diry_d  = 1'b0;
                    end else if (fcnt_q >= period_m1) begin
                        fcnt_d = '0;
                        if ((dirx_q && hit_right) || (!dirx_q && hit_left)) begin
                            dirx_d  = ~dirx_q;
                            diry_d  = 1'b1;
                            dcnt_d  = '0;
                            state_d = DROP;
                        end else begin
                            x_d    = dirx_q ? (x_q + XW'(STEP_X)) : (x_q - XW'(STEP_X));
                            tick_d = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + CW'(1);
                    end
                end
                DROP: begin
                    if (bus.alive_count == 6'd0) begin
                        state_d = HALT;
                        clr_d   = 1'b1;
                        diry_d  = 1'b0;
                    end else begin
                        y_d = y_q + XW'(1);
                        if (dcnt_q >= CW'(DROP_FRAMES - 1)) begin
                            diry_d = 1'b0;
                            fcnt_d = '0;
                            dcnt_d = '0;
                            if (reach_lose) begin
                                state_d = HALT;
                                inv_d   = 1'b1;
                            end else begin
                                state_d = MARCH;
                            end
                        end else begin
                            dcnt_d = dcnt_q + CW'(1);
                        end
                    end
                end
                HALT: begin
                    diry_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= INIT_X;
            y_q     <= INIT_Y;
            dirx_q  <= 1'b1;
            diry_q  <= 1'b0;
            tick_q  <= 1'b0;
            inv_q   <= 1'b0;
            clr_q   <= 1'b0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
            tick_q  <= tick_d;
            inv_q   <= inv_d;
            clr_q   <= clr_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus.enemy_direction_X = dirx_q;
    assign bus.enemy_direction_Y = diry_q;
    assign bus.formation_x       = x_q;
    assign bus.formation_y       = y_q;
    assign bus.move_tick         = tick_q;
    assign bus.invaded           = inv_q;
    assign bus.wave_clear        = clr_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl; a second instance with INIT_Y=216 covers invasion.
module tb_enemy_formation_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARCH = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic frame_clk;
    logic Reset;
    int   total;
    int   bad;

    enemy_formation_if bus ();
    enemy_formation_if bus2 ();

    assign bus2.start       = bus.start;
    assign bus2.is_playing  = bus.is_playing;
    assign bus2.alive_count = bus.alive_count;

    enemy_formation_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    enemy_formation_ctrl #(.INIT_Y(10'd216)) dut2 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus2.slave)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        Reset           = 1'b1;
        bus.start       = 1'b0;
        bus.is_playing  = 1'b1;
        bus.alive_count = 6'd24;
        cyc(2);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.formation_x !== 10'd40) begin bad++; $display("FAIL rst_x got=%0d want=40", bus.formation_x); end
        total++; if (bus.formation_y !== 10'd40) begin bad++; $display("FAIL rst_y got=%0d want=40", bus.formation_y); end
        total++; if ({bus.enemy_direction_X, bus.enemy_direction_Y, bus.move_tick, bus.invaded, bus.wave_clear} !== 5'b10000) begin
            bad++; $display("FAIL rst_flags got=%b want=10000",
                {bus.enemy_direction_X, bus.enemy_direction_Y, bus.move_tick, bus.invaded, bus.wave_clear});
        end
        total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state_q, S_IDLE); end
        cyc(5);
        total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL idle_hold got=%0d want=%0d", dut.state_q, S_IDLE); end
    endtask

    task automatic test_first_step();
        int early_ticks;
        do_reset();
        bus.start = 1'b1;
        cyc(1);
        early_ticks = 0;
        for (int i = 0; i < 29; i++) begin
            cyc(1);
            if (bus.move_tick) early_ticks++;
        end
        total++; if (early_ticks != 0 || bus.formation_x !== 10'd40) begin
            bad++; $display("FAIL step_early ticks=%0d x=%0d want 0/40", early_ticks, bus.formation_x);
        end
        cyc(1);
        total++; if (bus.formation_x !== 10'd44 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL step_first x=%0d tick=%b want 44/1", bus.formation_x, bus.move_tick);
        end
        cyc(1);
        total++; if (bus.move_tick !== 1'b0) begin bad++; $display("FAIL step_pulse tick=%b want 0", bus.move_tick); end
    endtask

    task automatic test_edge_drop();
        do_reset();
        bus.start = 1'b1;
        cyc(1);
        cyc(30 * 48);
        total++; if (bus.formation_x !== 10'd232) begin bad++; $display("FAIL edge_x48 got=%0d want=232", bus.formation_x); end
        cyc(30);
        total++; if (bus.enemy_direction_X !== 1'b0 || bus.enemy_direction_Y !== 1'b1 || bus.move_tick !== 1'b0
                     || bus.formation_x !== 10'd232 || dut.state_q !== S_DROP) begin
            bad++; $display("FAIL edge_hit dx=%b dy=%b tick=%b x=%0d st=%0d want 0/1/0/232/2",
                bus.enemy_direction_X, bus.enemy_direction_Y, bus.move_tick, bus.formation_x, dut.state_q);
        end
        cyc(7);
        total++; if (bus.enemy_direction_Y !== 1'b1 || bus.formation_y !== 10'd47) begin
            bad++; $display("FAIL drop_mid dy=%b y=%0d want 1/47", bus.enemy_direction_Y, bus.formation_y);
        end
        cyc(1);
        total++; if (bus.enemy_direction_Y !== 1'b0 || bus.formation_y !== 10'd48 || bus.formation_x !== 10'd232
                     || dut.state_q !== S_MARCH) begin
            bad++; $display("FAIL drop_end dy=%b y=%0d x=%0d st=%0d want 0/48/232/1",
                bus.enemy_direction_Y, bus.formation_y, bus.formation_x, dut.state_q);
        end
        cyc(30);
        total++; if (bus.formation_x !== 10'd228 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL march_left x=%0d tick=%b want 228/1", bus.formation_x, bus.move_tick);
        end
    endtask

    task automatic test_speed();
        do_reset();
        bus.alive_count = 6'd4;
        bus.start = 1'b1;
        cyc(11);
        total++; if (bus.formation_x !== 10'd44 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL spd4_a x=%0d tick=%b want 44/1", bus.formation_x, bus.move_tick);
        end
        cyc(9);
        total++; if (bus.formation_x !== 10'd44 || bus.move_tick !== 1'b0) begin
            bad++; $display("FAIL spd4_b x=%0d tick=%b want 44/0", bus.formation_x, bus.move_tick);
        end
        cyc(1);
        total++; if (bus.formation_x !== 10'd48 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL spd4_c x=%0d tick=%b want 48/1", bus.formation_x, bus.move_tick);
        end
        bus.alive_count = 6'd1;
        cyc(6);
        total++; if (bus.formation_x !== 10'd48 || bus.move_tick !== 1'b0) begin
            bad++; $display("FAIL spd1_a x=%0d tick=%b want 48/0", bus.formation_x, bus.move_tick);
        end
        cyc(1);
        total++; if (bus.formation_x !== 10'd52 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL spd1_b x=%0d tick=%b want 52/1", bus.formation_x, bus.move_tick);
        end
        bus.alive_count = 6'd0;
        cyc(1);
        total++; if (bus.wave_clear !== 1'b1 || dut.state_q !== S_HALT || bus.move_tick !== 1'b0) begin
            bad++; $display("FAIL clear clr=%b st=%0d tick=%b want 1/3/0", bus.wave_clear, dut.state_q, bus.move_tick);
        end
        bus.alive_count = 6'd5;
        cyc(20);
        total++; if (bus.formation_x !== 10'd52 || dut.state_q !== S_HALT || bus.wave_clear !== 1'b1) begin
            bad++; $display("FAIL halt_hold x=%0d st=%0d clr=%b want 52/3/1", bus.formation_x, dut.state_q, bus.wave_clear);
        end
    endtask

    task automatic test_invasion();
        do_reset();
        total++; if (bus2.formation_y !== 10'd216) begin bad++; $display("FAIL inv_init y=%0d want=216", bus2.formation_y); end
        bus.start = 1'b1;
        cyc(1 + 30 * 49 + 8);
        total++; if (bus2.formation_y !== 10'd224 || bus2.invaded !== 1'b1 || dut2.state_q !== S_HALT
                     || bus2.enemy_direction_Y !== 1'b0) begin
            bad++; $display("FAIL invade y=%0d inv=%b st=%0d dy=%b want 224/1/3/0",
                bus2.formation_y, bus2.invaded, dut2.state_q, bus2.enemy_direction_Y);
        end
        total++; if (bus.invaded !== 1'b0 || bus.formation_y !== 10'd48) begin
            bad++; $display("FAIL no_invade inv=%b y=%0d want 0/48", bus.invaded, bus.formation_y);
        end
        cyc(40);
        total++; if (bus2.formation_x !== 10'd232 || bus2.formation_y !== 10'd224 || dut2.state_q !== S_HALT) begin
            bad++; $display("FAIL inv_hold x=%0d y=%0d st=%0d want 232/224/3", bus2.formation_x, bus2.formation_y, dut2.state_q);
        end
    endtask

    task automatic test_pause();
        int pause_ticks;
        do_reset();
        bus.start = 1'b1;
        cyc(16);
        bus.is_playing = 1'b0;
        pause_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (bus.move_tick) pause_ticks++;
        end
        total++; if (pause_ticks != 0 || bus.formation_x !== 10'd40 || dut.fcnt_q !== 8'd15) begin
            bad++; $display("FAIL pause ticks=%0d x=%0d fcnt=%0d want 0/40/15", pause_ticks, bus.formation_x, dut.fcnt_q);
        end
        bus.is_playing = 1'b1;
        cyc(14);
        total++; if (bus.formation_x !== 10'd40 || bus.move_tick !== 1'b0) begin
            bad++; $display("FAIL resume_a x=%0d tick=%b want 40/0", bus.formation_x, bus.move_tick);
        end
        cyc(1);
        total++; if (bus.formation_x !== 10'd44 || bus.move_tick !== 1'b1) begin
            bad++; $display("FAIL resume_b x=%0d tick=%b want 44/1", bus.formation_x, bus.move_tick);
        end
    endtask

    task automatic test_reset_mid_drop();
        do_reset();
        bus.start = 1'b1;
        cyc(1 + 30 * 49 + 4);
        total++; if (dut.state_q !== S_DROP || bus.formation_y !== 10'd44) begin
            bad++; $display("FAIL pre_rst st=%0d y=%0d want 2/44", dut.state_q, bus.formation_y);
        end
        Reset = 1'b1;
        cyc(1);
        total++; if (bus.formation_x !== 10'd40 || bus.formation_y !== 10'd40 || bus.enemy_direction_X !== 1'b1
                     || bus.enemy_direction_Y !== 1'b0 || dut.state_q !== S_IDLE) begin
            bad++; $display("FAIL rst_drop x=%0d y=%0d dx=%b dy=%b st=%0d want 40/40/1/0/0",
                bus.formation_x, bus.formation_y, bus.enemy_direction_X, bus.enemy_direction_Y, dut.state_q);
        end
        Reset = 1'b0;
        cyc(1 + 30 * 49 - 1);
        bus.alive_count = 6'd0;
        cyc(1);
        total++; if (bus.wave_clear !== 1'b1 || bus.invaded !== 1'b0 || dut.state_q !== S_HALT
                     || bus.enemy_direction_X !== 1'b1 || bus.enemy_direction_Y !== 1'b0 || bus.formation_x !== 10'd232) begin
            bad++; $display("FAIL clr_prio clr=%b inv=%b st=%0d dx=%b dy=%b x=%0d want 1/0/3/1/0/232",
                bus.wave_clear, bus.invaded, dut.state_q, bus.enemy_direction_X, bus.enemy_direction_Y, bus.formation_x);
        end
        total++; if (bus2.wave_clear !== 1'b1 || bus2.invaded !== 1'b0) begin
            bad++; $display("FAIL clr_prio2 clr=%b inv=%b want 1/0", bus2.wave_clear, bus2.invaded);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        Reset           = 1'b1;
        bus.start       = 1'b0;
        bus.is_playing  = 1'b1;
        bus.alive_count = 6'd24;
        @(negedge frame_clk);
        test_reset();
        test_first_step();
        test_edge_drop();
        test_speed();
        test_invasion();
        test_pause();
        test_reset_mid_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
